// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode, alu_op, mux-select and state encodings for the multicycle MIPS control unit
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGT   = 6'b000111;
    localparam logic [5:0] OP_BLT   = 6'b000110;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_OP_ADD   = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_BNE   = 3'b011;
    localparam logic [2:0] ALU_OP_BGT   = 3'b111;
    localparam logic [2:0] ALU_OP_BLT   = 3'b101;
    localparam logic [2:0] ALU_OP_RTYPE = 3'b010;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SL2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    // Compare flavour handed to the ALU control stage for each branch opcode
    function automatic logic [2:0] branch_alu_op(input logic [5:0] op);
        case (op)
            OP_BNE:  return ALU_OP_BNE;
            OP_BGT:  return ALU_OP_BGT;
            OP_BLT:  return ALU_OP_BLT;
            default: return ALU_OP_SUB;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS main control FSM; ILLEGAL_TRAP_EN makes unknown opcodes halt
module mc_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    // State and sticky illegal flag; async reset so outputs fall back to FETCH decode at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs decode from the current state only (FETCH also qualifies its loads by mem_ready)
    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALU_OP_ADD;
        pc_source     = PC_SRC_ALU;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM_SL2;
                case (opcode)
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_RTYPE:                         state_d = S_EXECUTE;
                    OP_ADDI:                          state_d = S_ADDI_EX;
                    OP_BEQ, OP_BNE, OP_BGT, OP_BLT:   state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    default: begin
                        illegal_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                        state_d   = S_HALT;
`else
                        state_d   = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_RTYPE;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
                alu_op        = branch_alu_op(opcode);
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign illegal_op = illegal_q;
    assign state      = state_q;

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle main control unit for the MIPS datapath. Decodes the 6-bit instruction opcode over a sequence of Moore states and drives every datapath enable and mux select, including the 3-bit `alu_op` consumed directly by the downstream ALU control stage. It handles memory wait states through a ready handshake and flags unsupported opcodes.

## Interface
Parameters:
- none; the state and opcode encodings are fixed package constants.

Ports:
- `clk` in 1: single clock; all state updates happen on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `opcode` in 6: the instruction register `[31:26]`, valid from DECODE onward.
- `mem_ready` in 1: memory has completed the current access.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load qualified by the ALU zero/compare result.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: instruction register load.
- `mem_to_reg` out 1: register write-data select (1 = MDR).
- `reg_dst` out 1: destination register select (1 = rd, 0 = rt).
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: ALU A select (0 = PC, 1 = register A).
- `alu_src_b` out 2: ALU B select (00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = immediate shifted left 2).
- `alu_op` out 3: ALU operation class for the ALU control stage.
- `pc_source` out 2: PC source select (00 = ALU, 01 = ALUOut, 10 = jump target).
- `illegal_op` out 1: sticky flag for an unsupported opcode.
- `state` out 4: current state, for debug.

## Operation
- Opcodes:
  - R 000000
  - lw 100011
  - sw 101011
  - addi 001000
  - beq 000100
  - bne 000101
  - bgt 000111
  - blt 000110
  - j 000010
- `alu_op` codes:
  - 000 add
  - 001 beq/sub
  - 011 bne
  - 111 bgt
  - 101 blt
  - 010 R-type (funct decides)
- States and encodings:
  - FETCH 0
  - DECODE 1
  - MEM_ADDR 2
  - MEM_READ 3
  - MEM_WB 4
  - MEM_WRITE 5
  - EXECUTE 6
  - ALU_WB 7
  - BRANCH 8
  - JUMP 9
  - ADDI_EX 10
  - ADDI_WB 11
  - HALT 12
- Moore outputs. Every output not listed for a state is 0.
- FETCH:
  - Asserts `mem_read=1`, `alu_src_b=01`, `alu_op=000`.
  - When `mem_ready=1`, also asserts `ir_write=1` and `pc_write=1`, then goes to DECODE. Otherwise it stays in FETCH.
- DECODE: asserts `alu_src_b=11`, `alu_op=000` to compute the branch target. Next state by opcode:
  - lw/sw → MEM_ADDR
  - R → EXECUTE
  - addi → ADDI_EX
  - beq/bne/bgt/blt → BRANCH
  - j → JUMP
  - any other opcode → illegal handling (see Configuration)
- MEM_ADDR: `alu_src_a=1`, `alu_src_b=10`, `alu_op=000`. Goes to MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: `mem_read=1`, `iord=1`. Holds until `mem_ready=1`, then goes to MEM_WB.
- MEM_WB: `reg_write=1`, `mem_to_reg=1`, `reg_dst=0`. Goes to FETCH.
- MEM_WRITE: `mem_write=1`, `iord=1`. Holds until `mem_ready=1`, then goes to FETCH.
- EXECUTE: `alu_src_a=1`, `alu_src_b=00`, `alu_op=010`. Goes to ALU_WB.
- ALU_WB: `reg_write=1`, `reg_dst=1`. Goes to FETCH.
- ADDI_EX: `alu_src_a=1`, `alu_src_b=10`, `alu_op=000`. Goes to ADDI_WB.
- ADDI_WB: `reg_write=1`, `reg_dst=0`. Goes to FETCH.
- BRANCH:
  - Asserts `alu_src_a=1`, `alu_src_b=00`, `pc_write_cond=1`, `pc_source=01`.
  - `alu_op` is taken from the opcode per the table above.
  - Goes to FETCH.
- JUMP: `pc_write=1`, `pc_source=10`. Goes to FETCH.
- `opcode` is sampled only in DECODE and the state that follows it. The instruction register holds it stable from the end of FETCH.

## Timing
- Reset (asynchronous, `rst_n=0`):
  - `state`=FETCH.
  - `illegal_op`=0.
  - Outputs show FETCH decode immediately: `mem_read=1`, `alu_src_b=01`, everything else 0.
- Cycle counts with `mem_ready` tied high:
  - lw 5
  - sw 4
  - R 4
  - addi 4
  - branch 3
  - j 3
- Each low cycle of `mem_ready` in FETCH, MEM_READ or MEM_WRITE adds one cycle. Request outputs stay asserted and stable throughout the wait.
- `mem_ready` is ignored in every state that does not access memory.
- Reset asserted mid-instruction aborts it at once. No partial write is held: `reg_write` and `mem_write` drop asynchronously.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE sets `illegal_op=1` and enters HALT.
  - HALT drives all outputs 0 and is left only by reset.
- `ILLEGAL_TRAP_EN` undefined:
  - An unknown opcode sets `illegal_op=1` and returns to FETCH as a NOP.
  - HALT is unreachable.
- In both builds, `illegal_op` clears only on reset.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the opcode localparams
  - the `alu_op` code localparams
  - the state enum typedef (4-bit)
  - the `alu_src_b` and `pc_source` encodings
- The ALU control stage also imports the `alu_op` constants from this package.
- No sub-module: one state register plus a next-state/output combinational block.

## Test plan
- Reset, then lw (100011) with `mem_ready=1`:
  - state sequence 0,1,2,3,4,0
  - `reg_write=1` and `mem_to_reg=1` only in state 4
- sw with `mem_ready` low for 3 cycles in MEM_WRITE:
  - `mem_write=1` and `iord=1` held for 4 cycles
  - returns to FETCH after `mem_ready` rises
- R-type:
  - `alu_op=010` in EXECUTE
  - then `reg_write=1`, `reg_dst=1`
  - 4 cycles total
- beq/bne/bgt/blt in BRANCH:
  - `alu_op`=001/011/111/101 respectively
  - `pc_write_cond=1`, `pc_source=01`
- Opcode 111111:
  - with the macro: `illegal_op=1`, state stays 12 for 10 cycles
  - without it: back to 0 next cycle, `illegal_op` stays 1
- `rst_n` pulsed low during MEM_WB: `reg_write` falls without waiting for a clock edge; after release, `state=0`.
